// File: rtl/acc64_seq_pkg.sv
// Shared encodings for the acc64_seq accumulator: operation codes and FSM states.
package acc64_seq_pkg;

    localparam int ACC_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } opT;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } stateT;

endpackage

// File: rtl/acc64_seq_rca64.sv
// RCA64: 64-bit ripple-carry adder, purely combinational.
module rca64
    import acc64_seq_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    input  logic                 cIn,
    output logic [ACC_WIDTH-1:0] s,
    output logic                 cOut
);

    logic [ACC_WIDTH:0] carry;

    // The carry chain lives inside one process so each stage sees the previous carry directly.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cIn;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cOut = carry[ACC_WIDTH];
    end

endmodule

// File: rtl/acc64_seq.sv
// Streaming 64-bit accumulator around RCA64: accepts ADD/SUB/LOAD/CLEAR operands and
// presents total, sticky overflow flags and operand count once a last operand arrives.
module acc64_seq
    import acc64_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_uovf,
    output logic             out_sovf,
    output logic [CNT_W-1:0] out_count
);

    stateT            stateReg, stateNext;
    logic [WIDTH-1:0] accReg, accNext;
    logic             uovfReg, uovfNext;
    logic             sovfReg, sovfNext;
    logic [CNT_W-1:0] countReg, countNext;

    opT               opSel;
    logic             isSub;
    logic [WIDTH-1:0] addB;
    logic [WIDTH-1:0] addS;
    logic             addCout;
    logic             accept;
    logic [CNT_W-1:0] countInc;

    assign opSel  = opT'(in_op);
    assign isSub  = (opSel == OP_SUB);
    assign addB   = isSub ? ~in_data : in_data;
    assign accept = in_valid & in_ready;

    // Saturating increment: the count sticks at its all-ones value.
    assign countInc = (countReg == {CNT_W{1'b1}}) ? countReg : countReg + 1'b1;

    rca64 u_rca64 (
        .a    (accReg),
        .b    (addB),
        .cIn  (isSub),
        .s    (addS),
        .cOut (addCout)
    );

    always_comb begin
        stateNext = stateReg;
        accNext   = accReg;
        uovfNext  = uovfReg;
        sovfNext  = sovfReg;
        countNext = countReg;
        case (stateReg)
            S_ACCUM: begin
                if (accept) begin
                    case (opSel)
                        OP_ADD: begin
                            accNext   = addS;
                            uovfNext  = uovfReg | addCout;
                            sovfNext  = sovfReg | ((accReg[WIDTH-1] == in_data[WIDTH-1]) &
                                                   (addS[WIDTH-1] != accReg[WIDTH-1]));
                            countNext = countInc;
                        end
                        OP_SUB: begin
                            accNext   = addS;
                            uovfNext  = uovfReg | ~addCout;
                            sovfNext  = sovfReg | ((accReg[WIDTH-1] != in_data[WIDTH-1]) &
                                                   (addS[WIDTH-1] != accReg[WIDTH-1]));
                            countNext = countInc;
                        end
                        OP_LOAD: begin
                            accNext   = in_data;
                            uovfNext  = 1'b0;
                            sovfNext  = 1'b0;
                            countNext = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        default: begin
                            accNext   = '0;
                            uovfNext  = 1'b0;
                            sovfNext  = 1'b0;
                            countNext = '0;
                        end
                    endcase
                    if (in_last) begin
                        stateNext = S_HOLD;
                    end
                end
            end
            default: begin
                // Result handed off: wipe the accumulator for the next transaction.
                if (out_ready) begin
                    stateNext = S_ACCUM;
                    accNext   = '0;
                    uovfNext  = 1'b0;
                    sovfNext  = 1'b0;
                    countNext = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= S_ACCUM;
            accReg   <= '0;
            uovfReg  <= 1'b0;
            sovfReg  <= 1'b0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            accReg   <= accNext;
            uovfReg  <= uovfNext;
            sovfReg  <= sovfNext;
            countReg <= countNext;
        end
    end

    assign in_ready  = (stateReg == S_ACCUM);
    assign out_valid = (stateReg == S_HOLD);
    assign out_sum   = accReg;
    assign out_uovf  = uovfReg;
    assign out_sovf  = sovfReg;
    assign out_count = countReg;

endmodule

// File: tb/tb_acc64_seq.sv
// Directed self-checking bench for acc64_seq with hand-computed expected values.
module tb_acc64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_op;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_uovf;
    logic        out_sovf;
    logic [7:0]  out_count;

    int nAsserts = 0;
    int nFails   = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    always #5 clk = ~clk;

    acc64_seq #(.WIDTH(64), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_uovf  (out_uovf),
        .out_sovf  (out_sovf),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] data, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("op=%0d data=%h last=%0b -> sum=%h cnt=%0d u=%0b s=%0b ov=%0b",
                 op, data, last, out_sum, out_count, out_uovf, out_sovf, out_valid);
    endtask

    task automatic checkResult(input string tag, input logic [63:0] sum, input logic [7:0] cnt,
                               input logic u, input logic s);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_count"}, {56'd0, out_count}, {56'd0, cnt});
        chk({tag, "_uovf"}, {63'd0, out_uovf}, {63'd0, u});
        chk({tag, "_sovf"}, {63'd0, out_sovf}, {63'd0, s});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_drain_sum"}, out_sum, 64'd0);
        chk({tag, "_drain_count"}, {56'd0, out_count}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = ADD; in_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sum", out_sum, 64'd0);
        chk("rst_count", {56'd0, out_count}, 64'd0);
        chk("rst_flags", {62'd0, out_uovf, out_sovf}, 64'd0);

        // Plain sum with a stalled consumer
        send(ADD, 64'd5, 1'b0);
        chk("t1_mirror_sum", out_sum, 64'd5);
        chk("t1_mirror_cnt", {56'd0, out_count}, 64'd1);
        send(ADD, 64'd7, 1'b0);
        send(ADD, 64'd30, 1'b1);
        checkResult("t1", 64'd42, 8'd3, 1'b0, 1'b0);
        in_valid = 1'b1; in_op = ADD; in_data = 64'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkResult("t1_stall", 64'd42, 8'd3, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        drain("t1");

        // Unsigned wrap
        send(LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(ADD, 64'd1, 1'b1);
        checkResult("t2", 64'd0, 8'd2, 1'b1, 1'b0);
        drain("t2");

        // Sticky signed overflow
        send(LOAD, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(ADD, 64'd1, 1'b0);
        chk("t3_mid_sum", out_sum, 64'h8000_0000_0000_0000);
        send(SUB, 64'd1, 1'b1);
        checkResult("t3", 64'h7FFF_FFFF_FFFF_FFFF, 8'd3, 1'b0, 1'b1);
        drain("t3");

        // Borrow on subtraction
        send(LOAD, 64'd3, 1'b0);
        send(SUB, 64'd5, 1'b1);
        checkResult("t4", 64'hFFFF_FFFF_FFFF_FFFE, 8'd2, 1'b1, 1'b0);
        drain("t4");

        // CLEAR with last yields zero result
        send(ADD, 64'd5, 1'b0);
        send(CLR, 64'd99, 1'b1);
        checkResult("t5", 64'd0, 8'd0, 1'b0, 1'b0);
        drain("t5");

        // Counter saturation over 300 back-to-back operands
        in_valid = 1'b1; in_op = ADD; in_data = 64'd1;
        for (int i = 1; i <= 300; i++) begin
            in_last = (i == 300);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        $display("300xADD1 -> sum=%0d cnt=%0d valid=%0b", out_sum, out_count, out_valid);
        checkResult("t6", 64'd300, 8'd255, 1'b0, 1'b0);
        drain("t6");

        // Reset mid-transaction
        send(ADD, 64'd9, 1'b0);
        send(ADD, 64'd9, 1'b0);
        chk("t7_pre_sum", out_sum, 64'd18);
        rst = 1'b1; in_valid = 1'b1; in_op = ADD; in_data = 64'd9;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t7_rst_sum", out_sum, 64'd0);
        chk("t7_rst_count", {56'd0, out_count}, 64'd0);
        chk("t7_rst_valid", {63'd0, out_valid}, 64'd0);
        send(ADD, 64'd4, 1'b1);
        checkResult("t7", 64'd4, 8'd1, 1'b0, 1'b0);

        // Reset discards a pending result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8_valid", {63'd0, out_valid}, 64'd0);
        chk("t8_ready", {63'd0, in_ready}, 64'd1);
        chk("t8_sum", out_sum, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
